pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised successor of the 16-bit program counter: configurable width, step and reset vector.
- Adds a hardware return-address stack, so call/return executes in one cycle without RAM traffic.
- Sits between the instruction decoder and ROM32K address input in the CPU.
- Reports stack occupancy and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 16, bit width of the PC, of `in`, of `out` and of each stack entry.
- DEPTH, 8, number of return-address entries; power of two, at least 2.
- STEP, 1, increment added on inc and used to form the return address; WIDTH-bit unsigned.
- RESET_VAL, 0, value loaded into the PC on reset.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous reset, active-low (asserted at 0).
- in, input, WIDTH, jump or call target.
- load, input, 1, jump: PC <= in.
- inc, input, 1, PC <= PC + STEP.
- call, input, 1, push PC + STEP, then PC <= in.
- ret, input, 1, pop top of stack into PC.
- clr_err, input, 1, clears the sticky error flags.
- out, output, WIDTH, current PC; a registered value.
- depth, output, $clog2(DEPTH)+1, number of valid stack entries.
- full, output, 1, depth == DEPTH.
- empty, output, 1, depth == 0.
- overflow, output, 1, sticky: a call occurred while the stack was full.
- underflow, output, 1, sticky: a ret occurred while the stack was empty.

Behaviour:
- Reset (asynchronous, reset==0):
  - out = RESET_VAL, depth = 0, empty = 1, full = 0.
  - overflow = 0, underflow = 0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts any op immediately.
  - The first edge after release executes normally.
- Per rising edge, exactly one op executes. Priority: ret > call > load > inc > hold.
  - Lower-priority strobes asserted in the same cycle are ignored.
- hold: nothing changes.
- inc: out <= out + STEP, modulo 2^WIDTH; wraps from max to STEP-1 silently.
- load: out <= in; the stack is untouched.
- call, not full:
  - stack[depth] <= out + STEP (mod 2^WIDTH).
  - depth <= depth + 1.
  - out <= in.
- call, full:
  - out <= in.
  - Return address is discarded; depth unchanged.
  - overflow <= 1.
- ret, not empty:
  - out <= stack[depth-1].
  - depth <= depth - 1.
- ret, empty:
  - out unchanged; depth stays 0.
  - underflow <= 1.
- clr_err: clears overflow and underflow on the edge.
  - An error raised in the same cycle wins: the flag is set.
- Latency: every op takes effect on the edge where it is sampled, so out changes one cycle after the strobe.
- Status outputs:
  - full and empty decode directly from the depth register.
  - There is no combinational path from inputs to any output.

Optional Feature:
- PC_STACK_CIRCULAR_EN
  - Defined:
    - The stack is a circular buffer.
    - A call when full overwrites the oldest entry; depth stays DEPTH.
    - overflow is never set (tied 0).
    - A ret after wrap returns the most recent DEPTH addresses in LIFO order.
  - Undefined: the drop-and-flag behaviour above.

Decomposition:
- Package pc_stack_pkg holds:
  - an op enum: OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET;
  - a priority-encode function from the strobes to the op;
  - the DEPTH legality check constant.
- Sub-module lifo_stack:
  - parametrised WIDTH/DEPTH;
  - push/pop/data ports plus depth/full/empty;
  - owns the pointer and circular-mode logic.
- pc_stack holds the PC register, the increment/mux path and the error flags.

Test Plan:
- Reset and inc (WIDTH=16, RESET_VAL=0x0100): reset=0 then release; inc for 3 cycles -> out = 0x0100, 0x0101, 0x0102, 0x0103; depth = 0, empty = 1.
- Call/ret pair: out = 0x0010; call with in = 0x0200 -> out = 0x0200, depth = 1; next cycle ret -> out = 0x0011, depth = 0.
- Priority: load=1, inc=1, in = 0x1234 -> out = 0x1234; then call=1, ret=1 with depth 0 -> ret wins, underflow = 1, out unchanged.
- Overflow with DEPTH=4:
  - 5 nested calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> full = 1, overflow = 1.
  - Then 4 rets -> out = 0x41, 0x31, 0x21, 0x11.
  - With PC_STACK_CIRCULAR_EN: rets -> 0x51, 0x41, 0x31, 0x21; overflow stays 0.
- Wrap and clear: out = 0xFFFF, inc -> out = 0x0000. Then with underflow = 1: clr_err alone -> 0; clr_err plus ret on an empty stack -> underflow stays 1.
- Async reset mid-call: assert reset between edges with depth = 3 -> out = RESET_VAL and depth = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg
// Shared definitions for the pc_stack block:
//   op_t         - the single operation executed on a clock edge
//   encode_op()  - priority encoder from the raw strobes (ret > call > load > inc)
//   MIN_DEPTH,
//   depth_legal() - legality check for the return-stack DEPTH parameter
package pc_stack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_t;

  localparam int MIN_DEPTH = 2;

  // DEPTH must be a power of two so the circular pointer wraps for free.
  function automatic bit depth_legal(input int d);
    return (d >= MIN_DEPTH) && ((d & (d - 1)) == 0);
  endfunction

  function automatic op_t encode_op(input logic load, input logic inc,
                                    input logic call, input logic ret);
    if (ret)       return OP_RET;
    else if (call) return OP_CALL;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if
// Groups the decoder-side controls and the PC/status outputs of pc_stack.
//   master : drives in/load/inc/call/ret/clr_err, observes out and status
//   slave  : the pc_stack side
// Parameters WIDTH and DEPTH must match the attached pc_stack.
interface pc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic             clr_err;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output in, load, inc, call, ret, clr_err,
    input  out, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  in, load, inc, call, ret, clr_err,
    output out, depth, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_lifo_stack.sv
// lifo_stack
// Return-address LIFO used by pc_stack.
//   clock, reset (async, active-low)
//   push/push_data : store an entry on top
//   pop/pop_data   : pop_data always shows the current top entry
//   depth/full/empty : occupancy, decoded from the count register
// Optional macro PC_STACK_CIRCULAR_EN: a push while full overwrites the
// oldest entry instead of being dropped.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int DW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [DW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DW'(DEPTH));
  assign empty    = (count == '0);
  assign depth    = count;
  // ptr is the next free slot, so the top lives one below it (mod DEPTH).
  assign pop_data = mem[ptr - PW'(1)];

  assign do_pop = pop && !empty;
`ifdef PC_STACK_CIRCULAR_EN
  assign do_push = push && !pop;
`else
  assign do_push = push && !pop && !full;
`endif

  // Pointer and occupancy; in circular mode count saturates at DEPTH while
  // ptr keeps advancing over the oldest entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - DW'(1);
    end else if (do_push) begin
      ptr   <= ptr + PW'(1);
      count <= full ? count : count + DW'(1);
    end
  end

  // Entry storage needs no reset: contents are only read below count.
  always_ff @(posedge clock) begin
    if (do_push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_stack.sv
// pc_stack
// Program counter with a hardware return-address stack.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : pc_stack_if.slave
//           in/load/inc/call/ret/clr_err in; out/depth/full/empty/
//           overflow/underflow out (all registered)
// Priority per edge: ret > call > load > inc > hold.
// Optional macro PC_STACK_CIRCULAR_EN: circular return stack, overflow tied 0.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clock,
  input  logic       reset,
  pc_stack_if.slave  bus
);

  localparam int DW = $clog2(DEPTH) + 1;

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("pc_stack: DEPTH must be a power of two and at least 2");
  end

  op_t              op;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] top_data;
  logic [DW-1:0]    stk_depth;
  logic             stk_full;
  logic             stk_empty;
  logic             underflow_q;

  assign op          = encode_op(bus.load, bus.inc, bus.call, bus.ret);
  assign pc_next_seq = pc + STEP;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (op == OP_CALL),
    .pop       (op == OP_RET),
    .push_data (pc_next_seq),
    .pop_data  (top_data),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VAL;
    end else begin
      case (op)
        OP_RET:  if (!stk_empty) pc <= top_data;
        OP_CALL: pc <= bus.in;
        OP_LOAD: pc <= bus.in;
        OP_INC:  pc <= pc_next_seq;
        default: pc <= pc;
      endcase
    end
  end

  // A newly raised error takes precedence over clr_err on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          underflow_q <= 1'b0;
    else if (op == OP_RET && stk_empty)  underflow_q <= 1'b1;
    else if (bus.clr_err)                underflow_q <= 1'b0;
  end

`ifdef PC_STACK_CIRCULAR_EN
  assign bus.overflow = 1'b0;
`else
  logic overflow_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          overflow_q <= 1'b0;
    else if (op == OP_CALL && stk_full)  overflow_q <= 1'b1;
    else if (bus.clr_err)                overflow_q <= 1'b0;
  end

  assign bus.overflow = overflow_q;
`endif

  assign bus.out       = pc;
  assign bus.depth     = stk_depth;
  assign bus.full      = stk_full;
  assign bus.empty     = stk_empty;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack
// Scoreboard bench for pc_stack (WIDTH=16, DEPTH=4, STEP=1, RESET_VAL=0x0100).
// The driver pushes hand-computed expectations after each edge; the monitor
// drains the queue on the falling edge (or on demand for the async reset).
module tb_pc_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             ovf;
    logic             unf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  exp_t sb_q[$];
  event sample_now;
  int   checks   = 0;
  int   failures = 0;

  pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(16'd1), .RESET_VAL(16'h0100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input exp_t e);
    logic full_e, empty_e;
    full_e  = (e.depth == DW'(DEPTH));
    empty_e = (e.depth == '0);
    checks++;
    if (bus.out !== e.out || bus.depth !== e.depth || bus.full !== full_e ||
        bus.empty !== empty_e || bus.overflow !== e.ovf || bus.underflow !== e.unf) begin
      failures++;
      $display("[TB] FAIL %s: got out=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, expected out=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
               e.name, bus.out, bus.depth, bus.full, bus.empty, bus.overflow, bus.underflow,
               e.out, e.depth, full_e, empty_e, e.ovf, e.unf);
    end
  endtask

  // Monitor: drain every pending expectation whenever outputs are stable.
  initial begin
    forever begin
      @(negedge clock or sample_now);
      while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  function automatic exp_t mk(input string n, input logic [WIDTH-1:0] o,
                              input int d, input logic ov, input logic un);
    exp_t e;
    e.name = n; e.out = o; e.depth = DW'(d); e.ovf = ov; e.unf = un;
    return e;
  endfunction

  // Strobes are {ret, call, load, inc, clr_err}.
  task automatic applyStimulus(input logic [4:0] s, input logic [WIDTH-1:0] in_v,
                               input exp_t e);
    @(negedge clock);
    {bus.ret, bus.call, bus.load, bus.inc, bus.clr_err} = s;
    bus.in = in_v;
    @(posedge clock);
    #1;
    sb_q.push_back(e);
  endtask

  localparam logic [4:0] S_HOLD = 5'b00000, S_INC = 5'b00010, S_LOAD = 5'b00100,
                         S_CALL = 5'b01000, S_RET = 5'b10000, S_CLR = 5'b00001;

  initial begin
    logic ovf_full;
`ifdef PC_STACK_CIRCULAR_EN
    ovf_full = 1'b0;
`else
    ovf_full = 1'b1;
`endif
    {bus.ret, bus.call, bus.load, bus.inc, bus.clr_err} = '0;
    bus.in = '0;

    // Reset held across an edge
    @(posedge clock); #1;
    sb_q.push_back(mk("reset", 16'h0100, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(S_INC,  16'h0, mk("inc1", 16'h0101, 0, 0, 0));
    applyStimulus(S_INC,  16'h0, mk("inc2", 16'h0102, 0, 0, 0));
    applyStimulus(S_INC,  16'h0, mk("inc3", 16'h0103, 0, 0, 0));
    applyStimulus(S_HOLD, 16'hBEEF, mk("hold", 16'h0103, 0, 0, 0));

    // Call/ret pair
    applyStimulus(S_LOAD, 16'h0010, mk("load10", 16'h0010, 0, 0, 0));
    applyStimulus(S_CALL, 16'h0200, mk("call200", 16'h0200, 1, 0, 0));
    applyStimulus(S_RET,  16'h0000, mk("ret11", 16'h0011, 0, 0, 0));

    // Priority
    applyStimulus(S_LOAD | S_INC, 16'h1234, mk("load_over_inc", 16'h1234, 0, 0, 0));
    applyStimulus(S_CALL | S_RET, 16'h5555, mk("ret_over_call", 16'h1234, 0, 0, 1));
    applyStimulus(S_CLR, 16'h0, mk("clr_alone", 16'h1234, 0, 0, 0));

    // Nested calls past DEPTH
    applyStimulus(S_LOAD, 16'h0010, mk("load_10", 16'h0010, 0, 0, 0));
    applyStimulus(S_CALL, 16'h0020, mk("call1", 16'h0020, 1, 0, 0));
    applyStimulus(S_CALL, 16'h0030, mk("call2", 16'h0030, 2, 0, 0));
    applyStimulus(S_CALL, 16'h0040, mk("call3", 16'h0040, 3, 0, 0));
    applyStimulus(S_CALL, 16'h0050, mk("call4", 16'h0050, 4, 0, 0));
    applyStimulus(S_CALL, 16'h0060, mk("call5_full", 16'h0060, 4, ovf_full, 0));
`ifdef PC_STACK_CIRCULAR_EN
    applyStimulus(S_RET, 16'h0, mk("ret1", 16'h0051, 3, 0, 0));
    applyStimulus(S_RET, 16'h0, mk("ret2", 16'h0041, 2, 0, 0));
    applyStimulus(S_RET, 16'h0, mk("ret3", 16'h0031, 1, 0, 0));
    applyStimulus(S_RET, 16'h0, mk("ret4", 16'h0021, 0, 0, 0));
    applyStimulus(S_CLR | S_RET, 16'h0, mk("clr_ret_empty", 16'h0021, 0, 0, 1));
`else
    applyStimulus(S_RET, 16'h0, mk("ret1", 16'h0041, 3, 1, 0));
    applyStimulus(S_RET, 16'h0, mk("ret2", 16'h0031, 2, 1, 0));
    applyStimulus(S_RET, 16'h0, mk("ret3", 16'h0021, 1, 1, 0));
    applyStimulus(S_RET, 16'h0, mk("ret4", 16'h0011, 0, 1, 0));
    applyStimulus(S_CLR | S_RET, 16'h0, mk("clr_ret_empty", 16'h0011, 0, 0, 1));
`endif
    applyStimulus(S_CLR, 16'h0, mk("clr_again", sb_q.size() >= 0 ?
`ifdef PC_STACK_CIRCULAR_EN
                  16'h0021
`else
                  16'h0011
`endif
                  : 16'h0, 0, 0, 0));

    // Wrap
    applyStimulus(S_LOAD, 16'hFFFF, mk("load_ffff", 16'hFFFF, 0, 0, 0));
    applyStimulus(S_INC,  16'h0, mk("wrap", 16'h0000, 0, 0, 0));

    // Async reset between edges with depth 3
    applyStimulus(S_LOAD, 16'h0500, mk("load500", 16'h0500, 0, 0, 0));
    applyStimulus(S_CALL, 16'h0600, mk("acall1", 16'h0600, 1, 0, 0));
    applyStimulus(S_CALL, 16'h0700, mk("acall2", 16'h0700, 2, 0, 0));
    applyStimulus(S_CALL, 16'h0800, mk("acall3", 16'h0800, 3, 0, 0));
    @(negedge clock);
    {bus.ret, bus.call, bus.load, bus.inc, bus.clr_err} = S_CALL;
    #1;
    reset = 1'b0;
    #1;
    sb_q.push_back(mk("async_reset", 16'h0100, 0, 0, 0));
    ->sample_now;
    #1;
    {bus.ret, bus.call, bus.load, bus.inc, bus.clr_err} = '0;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(S_INC, 16'h0, mk("after_reset", 16'h0101, 0, 0, 0));

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL timeout: got no completion, expected finish before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
